// File: rtl/dimm_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: takes one queue request at a time and expands it into
// ACT0, ACT1, RD/WR pair and PRE on the DRAM command slots, enforcing the DRAM timing.
module dimm_cmd_sequencer #(
  parameter int unsigned T_RCD   = 39,
  parameter int unsigned T_RAS   = 76,
  parameter int unsigned T_RTP   = 18,
  parameter int unsigned T_CWL   = 38,
  parameter int unsigned T_BURST = 8,
  parameter int unsigned T_WR    = 72,
  parameter int unsigned T_RP    = 39,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_oper,
  input  logic [35:0] req_addr,
  output logic        req_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        err_oper,
  output logic        busy
);

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready; req_ready is
  // registered and only rises when the FSM is idle and the precharge window has closed.

  localparam int unsigned PRE_RD_I = (T_RAS > T_RCD + T_RTP) ? T_RAS : T_RCD + T_RTP;
  localparam int unsigned PRE_WR_I = (T_RAS > T_RCD + T_CWL + T_BURST + T_WR) ?
                                     T_RAS : T_RCD + T_CWL + T_BURST + T_WR;
  localparam logic [CNT_W-1:0] PRE_RD = CNT_W'(PRE_RD_I);
  localparam logic [CNT_W-1:0] PRE_WR = CNT_W'(PRE_WR_I);
  localparam logic [CNT_W-1:0] RCD_M1 = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP);

  localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                         C_RD1 = 3'd4, C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_CAS, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]   rp_cnt_q, rp_cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [33:2]        addr_q, addr_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [2:0]         cmd_code_q, cmd_code_d;
  logic               cmd_channel_q, cmd_channel_d;
  logic [2:0]         cmd_bg_q, cmd_bg_d;
  logic [1:0]         cmd_bank_q, cmd_bank_d;
  logic [15:0]        cmd_row_q, cmd_row_d;
  logic [9:0]         cmd_col_q, cmd_col_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               decide;
  logic               load_fields;
  logic [33:2]        addr_src;
  logic [CNT_W-1:0]   pre_slot;
  logic               unused_addr;

  assign unused_addr = ^{req_addr[35:34], req_addr[1:0]};
  assign accept      = req_valid && ready_q;
  // Commands are decided in phase-0 cycles so the registered command lands in the slot cycle.
  assign decide      = !phase_q;
  assign addr_src    = (state_q == S_IDLE) ? req_addr[33:2] : addr_q;
  assign pre_slot    = is_wr_q ? PRE_WR : PRE_RD;

  always_comb begin
    state_d       = state_q;
    phase_d       = !phase_q;
    slot_cnt_d    = slot_cnt_q;
    rp_cnt_d      = rp_cnt_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = C_NOP;
    cmd_channel_d = cmd_channel_q;
    cmd_bg_d      = cmd_bg_q;
    cmd_bank_d    = cmd_bank_q;
    cmd_row_d     = cmd_row_q;
    cmd_col_d     = cmd_col_q;
    err_d         = 1'b0;
    load_fields   = 1'b0;

    if (phase_q && (rp_cnt_q != '0)) rp_cnt_d = rp_cnt_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_oper == 2'd3) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_addr[33:2];
            is_wr_d = (req_oper == 2'd1);
            if (decide) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = C_ACT0;
              load_fields = 1'b1;
              slot_cnt_d  = CNT_W'(1);
              state_d     = S_ACT1;
            end else begin
              state_d = S_ACT0;
            end
          end
        end
      end
      S_ACT0: if (decide) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = C_ACT0;
        load_fields = 1'b1;
        slot_cnt_d  = CNT_W'(1);
        state_d     = S_ACT1;
      end
      S_ACT1: if (decide) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = C_ACT1;
        slot_cnt_d  = slot_cnt_q + 1'b1;
        state_d     = (slot_cnt_q == RCD_M1) ? S_CAS0 : S_WAIT_CAS;
      end
      S_WAIT_CAS: if (decide) begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == RCD_M1) state_d = S_CAS0;
      end
      S_CAS0: if (decide) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = is_wr_q ? C_WR0 : C_RD0;
        slot_cnt_d  = slot_cnt_q + 1'b1;
        state_d     = S_CAS1;
      end
      S_CAS1: if (decide) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = is_wr_q ? C_WR1 : C_RD1;
        slot_cnt_d  = slot_cnt_q + 1'b1;
        state_d     = (slot_cnt_q + 1'b1 == pre_slot) ? S_PRE : S_WAIT_PRE;
      end
      S_WAIT_PRE: if (decide) begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q + 1'b1 == pre_slot) state_d = S_PRE;
      end
      S_PRE: if (decide) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = C_PRE;
        slot_cnt_d  = '0;
        rp_cnt_d    = RP_LD;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Address fields only change when a new ACT0 goes out, so they hold through the whole sequence.
    if (load_fields) begin
      cmd_channel_d = addr_src[6];
      cmd_bg_d      = addr_src[9:7];
      cmd_bank_d    = addr_src[11:10];
      cmd_row_d     = addr_src[33:18];
      cmd_col_d     = {addr_src[17:12], addr_src[5:2]};
    end

    ready_d = (state_d == S_IDLE) && (rp_cnt_d == '0);
    busy_d  = (state_d != S_IDLE) || (rp_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      slot_cnt_q    <= '0;
      rp_cnt_q      <= '0;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= C_NOP;
      cmd_channel_q <= 1'b0;
      cmd_bg_q      <= '0;
      cmd_bank_q    <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      slot_cnt_q    <= slot_cnt_d;
      rp_cnt_q      <= rp_cnt_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_channel_q <= cmd_channel_d;
      cmd_bg_q      <= cmd_bg_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_channel = cmd_channel_q;
  assign cmd_bg      = cmd_bg_q;
  assign cmd_bank    = cmd_bank_q;
  assign cmd_row     = cmd_row_q;
  assign cmd_col     = cmd_col_q;
  assign err_oper    = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dimm_cmd_sequencer.sv
// Directed bench for dimm_cmd_sequencer: read, write, back-to-back, illegal-op and mid-sequence
// reset scenarios with hand-computed slot positions and address fields.
module tb_dimm_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_oper;
  logic [35:0] req_addr;
  logic        req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        err_oper;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cmd_cnt  = 0;

  dimm_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_oper(req_oper), .req_addr(req_addr),
    .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_channel(cmd_channel),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .err_oper(err_oper), .busy(busy)
  );

  // clock / reset-independent cycle bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cmd_valid) cmd_cnt = cmd_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // waits for the next command pulse; a timeout returns NOP so the caller's code check fails
  task automatic wait_cmd(output logic [2:0] code, output int at);
    code = 3'd0;
    at   = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        code = cmd_code;
        at   = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 600; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    chk("ready_wait", req_ready, 1'b1);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 1000; i++) begin
      if (cyc >= target) break;
      @(negedge clk);
    end
  endtask

  localparam logic [35:0] ADDR_A = 36'h012345678;
  localparam logic [35:0] ADDR_B = 36'h0ABCD1234;

  logic [2:0]  code;
  logic [35:0] addr_c;
  int          at, t0, k, n;

  initial begin
    addr_c    = 36'h0BEEF << 18;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_oper  = 2'd0;
    req_addr  = ADDR_A;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, cmd_valid, cmd_code, cmd_channel, cmd_bg, cmd_bank,
                          cmd_row, cmd_col, err_oper, busy}, 64'd0);

    // read of ADDR_A, request held valid through reset
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", req_ready, 1'b1);
    k = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_busy_after_accept", busy, 1'b1);
    chk("rd_ready_after_accept", req_ready, 1'b0);
    wait_cmd(code, at);
    t0 = at;
    chk("rd_act0_code", code, 3'd1);
    chk("rd_act0_latency", at - k, 2);
    chk("rd_act0_fields", {cmd_channel, cmd_bg, cmd_bank, cmd_row}, {1'b1, 3'd4, 2'd1, 16'h048D});
    wait_cmd(code, at);
    chk("rd_act1_code", code, 3'd2);
    chk("rd_act1_slot", at - t0, 2);
    wait_cmd(code, at);
    chk("rd_rd0_code", code, 3'd3);
    chk("rd_rd0_slot", at - t0, 2 * 39);
    chk("rd_rd0_col", cmd_col, 10'h05E);
    wait_cmd(code, at);
    chk("rd_rd1_code", code, 3'd4);
    chk("rd_rd1_slot", at - t0, 2 * 40);
    wait_cmd(code, at);
    chk("rd_pre_code", code, 3'd7);
    chk("rd_pre_slot", at - t0, 2 * 76);
    chk("rd_pre_row", cmd_row, 16'h048D);
    chk("rd_pre_busy", busy, 1'b1);

    // tRP boundary: ready rises in the phase-0 cycle just before slot 115
    wait_cyc(t0 + 2 * 114);
    chk("rd_rp_ready_slot114", req_ready, 1'b0);
    @(negedge clk);
    chk("rd_rp_ready_open", req_ready, 1'b1);
    chk("rd_rp_busy_clear", busy, 1'b0);

    // write of ADDR_A accepted immediately; ACT0 lands on slot 115 of the read
    k = cyc;
    req_valid = 1'b1;
    req_oper  = 2'd1;
    req_addr  = ADDR_A;
    wait_cmd(code, at);
    req_valid = 1'b0;
    chk("wr_act0_code", code, 3'd1);
    chk("wr_act0_latency", at - k, 1);
    chk("wr_act0_after_rp", at - t0, 2 * 115);
    t0 = at;
    wait_cmd(code, at);
    chk("wr_act1_code", code, 3'd2);
    wait_cmd(code, at);
    chk("wr_wr0_code", code, 3'd5);
    chk("wr_wr0_slot", at - t0, 2 * 39);
    wait_cmd(code, at);
    chk("wr_wr1_code", code, 3'd6);
    chk("wr_wr1_slot", at - t0, 2 * 40);
    wait_cmd(code, at);
    chk("wr_pre_code", code, 3'd7);
    chk("wr_pre_slot", at - t0, 2 * 157);
    wait_cyc(t0 + 2 * 195);
    chk("wr_busy_slot195", busy, 1'b1);
    @(negedge clk);
    chk("wr_busy_fall", busy, 1'b0);
    chk("wr_ready_rise", req_ready, 1'b1);

    // two back-to-back reads, second one held valid across ready low
    k = cyc;
    req_valid = 1'b1;
    req_oper  = 2'd0;
    req_addr  = ADDR_B;
    wait_cmd(code, at);
    req_addr = addr_c;
    chk("b2b_first_act0", code, 3'd1);
    chk("b2b_first_latency", at - k, 1);
    t0 = at;
    repeat (3) wait_cmd(code, at);
    chk("b2b_first_rd1", code, 3'd4);
    wait_cmd(code, at);
    chk("b2b_first_pre", code, 3'd7);
    chk("b2b_first_pre_slot", at - t0, 2 * 76);
    chk("b2b_ready_low", req_ready, 1'b0);
    wait_cmd(code, at);
    req_valid = 1'b0;
    chk("b2b_second_act0", code, 3'd1);
    chk("b2b_second_act0_slot", at - t0, 2 * 115);
    chk("b2b_second_row", {cmd_channel, cmd_bg, cmd_bank, cmd_row}, {6'd0, 16'hBEEF});
    t0 = at;
    repeat (3) wait_cmd(code, at);
    wait_cmd(code, at);
    chk("b2b_second_pre", code, 3'd7);
    chk("b2b_second_pre_slot", at - t0, 2 * 76);
    wait_ready();

    // illegal operation
    n = cmd_cnt;
    req_valid = 1'b1;
    req_oper  = 2'd3;
    req_addr  = ADDR_A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("op3_err_pulse", err_oper, 1'b1);
    chk("op3_ready_stays", req_ready, 1'b1);
    chk("op3_not_busy", busy, 1'b0);
    @(negedge clk);
    chk("op3_err_one_clk", err_oper, 1'b0);
    repeat (10) @(negedge clk);
    chk("op3_no_commands", cmd_cnt - n, 0);

    // reset after ACT1 aborts the sequence without a PRE
    req_valid = 1'b1;
    req_oper  = 2'd2;
    req_addr  = ADDR_B;
    wait_cmd(code, at);
    req_valid = 1'b0;
    chk("abort_act0", code, 3'd1);
    wait_cmd(code, at);
    chk("abort_act1", code, 3'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {req_ready, cmd_valid, cmd_code, cmd_row, cmd_col, err_oper, busy},
        64'd0);
    n = cmd_cnt;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_pre", cmd_cnt - n, 0);
    wait_ready();
    req_valid = 1'b1;
    req_oper  = 2'd0;
    req_addr  = ADDR_A;
    wait_cmd(code, at);
    req_valid = 1'b0;
    chk("restart_act0", code, 3'd1);
    chk("restart_row", cmd_row, 16'h048D);
    t0 = at;
    wait_cmd(code, at);
    chk("restart_act1_slot", at - t0, 2);
    wait_cmd(code, at);
    chk("restart_rd0", code, 3'd3);
    chk("restart_rd0_slot", at - t0, 2 * 39);
    wait_cmd(code, at);
    wait_cmd(code, at);
    chk("restart_pre_slot", at - t0, 2 * 76);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
